// File: rtl/div_rr_sched.sv
// Round-robin scheduler sharing one 16/8 shift-subtract divider (one quotient bit per clock).
// Handshake: a transfer happens on a rising edge where valid && ready are both high; ready never waits on nothing but arbitration/state.
module div_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [15:0]            resp_result,
  output logic [15:0]            resp_odd,
  output logic                   resp_dz,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [16:0]       rem_q, rem_d;
  logic [15:0]       quo_q, quo_d;
  logic [7:0]        b_q, b_d;
  logic [15:0]       res_q, res_d;
  logic [15:0]       odd_q, odd_d;
  logic              dz_q, dz_d;

  logic [2*NUM_REQ-1:0] shifted;
  logic [NUM_REQ-1:0]   rot;
  logic                 found;
  logic [ID_W-1:0]      win;
  logic [ID_W:0]        sum;
  logic [ID_W:0]        nxt;
  logic [15:0]          a_sel;
  logic [7:0]           b_sel;
  logic [17:0]          sh_rem;

  // Rotate the valid vector so that position 0 is the current pointer; first set bit wins.
  always_comb begin
    shifted = {req_valid, req_valid} >> ptr_q;
    rot     = shifted[NUM_REQ-1:0];
    found   = 1'b0;
    win     = '0;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_q} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
        win   = sum[ID_W-1:0];
      end
    end
    nxt = {1'b0, win} + (ID_W+1)'(1);
    if (nxt >= (ID_W+1)'(NUM_REQ)) nxt = '0;
  end

  always_comb begin
    a_sel     = '0;
    b_sel     = '0;
    req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win == ID_W'(j)) begin
        a_sel = req_a[16*j +: 16];
        b_sel = req_b[8*j +: 8];
        req_ready[j] = (state_q == IDLE) && found;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    b_d     = b_q;
    res_d   = res_q;
    odd_d   = odd_q;
    dz_d    = dz_q;
    sh_rem  = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          id_d  = win;
          ptr_d = nxt[ID_W-1:0];
          b_d   = b_sel;
          if (b_sel != 8'd0) begin
            state_d = CALC;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = a_sel;
          end else begin
            state_d = DONE;
            res_d   = 16'hFFFF;
            odd_d   = a_sel;
            dz_d    = 1'b1;
          end
        end
      end
      CALC: begin
        // Remainder stays below the divisor, so the shifted value always fits in 17 bits.
        sh_rem = {rem_q, quo_q[15]};
        quo_d  = {quo_q[14:0], 1'b0};
        if (sh_rem >= {10'b0, b_q}) begin
          rem_d    = 17'(sh_rem - {10'b0, b_q});
          quo_d[0] = 1'b1;
        end else begin
          rem_d = 17'(sh_rem);
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = DONE;
          res_d   = quo_d;
          odd_d   = rem_d[15:0];
          dz_d    = 1'b0;
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      b_q     <= '0;
      res_q   <= '0;
      odd_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      b_q     <= b_d;
      res_q   <= res_d;
      odd_q   <= odd_d;
      dz_q    <= dz_d;
    end
  end

  assign resp_valid  = (state_q == DONE);
  assign resp_id     = id_q;
  assign resp_result = res_q;
  assign resp_odd    = odd_q;
  assign resp_dz     = dz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_div_rr_sched.sv
// Bench for div_rr_sched: round-robin grant model plus arithmetic divide model, randomized ops.
module tb_div_rr_sched;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [16*N-1:0] req_a = '0;
  logic [8*N-1:0]  req_b = '0;
  logic [N-1:0]  req_ready;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [1:0]    resp_id;
  logic [15:0]   resp_result;
  logic [15:0]   resp_odd;
  logic          resp_dz;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int m_ptr = 0;
  logic [34:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  div_rr_sched #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .resp_odd(resp_odd),
    .resp_dz(resp_dz), .dbg_state(dbg_state)
  );

  function automatic logic [34:0] model(input int id, input logic [15:0] a, input logic [7:0] b);
    logic [15:0] q, r;
    if (b == 8'd0) return {2'(id), 1'b1, 16'hFFFF, a};
    q = a / {8'd0, b};
    r = a % {8'd0, b};
    return {2'(id), 1'b0, q, r};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] r);
    int n = 0;
    int idx = -1;
    for (int j = 0; j < N; j++) if (r[j]) begin n++; idx = j; end
    return (n == 1) ? idx : -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [7:0] b);
    req_a[16*i +: 16] = a;
    req_b[8*i +: 8]   = b;
  endtask

  // Waits (bounded) for a grant, then advances past the accept edge.
  task automatic do_grant(output logic [N-1:0] rdy, output bit ok);
    ok = 1'b0;
    rdy = '0;
    #1;
    for (int c = 0; c < 60; c++) begin
      if (req_ready != '0) begin
        rdy = req_ready;
        ok = 1'b1;
        break;
      end
      step();
    end
    if (ok) step();
  endtask

  // lat = 1 means resp_valid seen in the first cycle after the accept edge.
  task automatic wait_resp(output int lat, output bit ok);
    lat = 1;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (resp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      lat++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b0;
    step();
    step();
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    total++; if (resp_id !== 2'd0) begin bad++; $display("FAIL rst_resp_id: got %0d want 0", resp_id); end
    total++; if (resp_result !== 16'd0) begin bad++; $display("FAIL rst_result: got %h want 0000", resp_result); end
    total++; if (resp_odd !== 16'd0) begin bad++; $display("FAIL rst_odd: got %h want 0000", resp_odd); end
    total++; if (resp_dz !== 1'b0) begin bad++; $display("FAIL rst_dz: got %b want 0", resp_dz); end
    rst = 1'b0;
    m_ptr = 0;
  endtask

  // One op from a single requester with resp_ready high; returns the observed response.
  task automatic test_op(input string name, input int i, input logic [15:0] a, input logic [7:0] b,
                         output logic [34:0] got);
    logic [N-1:0] rdy;
    bit ok;
    int lat;
    logic [34:0] exp;
    got = '0;
    set_req(i, a, b);
    req_valid = N'(1 << i);
    resp_ready = 1'b1;
    exp = model(i, a, b);
    do_grant(rdy, ok);
    total++; if (!ok) begin bad++; $display("FAIL %s_grant: no grant within bound", name); return; end
    total++; if (oh_idx(rdy) != i) begin bad++; $display("FAIL %s_grant_id: got %b want %0d", name, rdy, i); end
    m_ptr = (i + 1) % N;
    req_valid = '0;
    set_req(i, 16'($urandom), 8'($urandom));
    wait_resp(lat, ok);
    total++; if (!ok) begin bad++; $display("FAIL %s_resp: no resp_valid within bound", name); return; end
    total++; if (lat != ((b == 8'd0) ? 1 : 17)) begin bad++; $display("FAIL %s_latency: got %0d want %0d", name, lat, (b == 8'd0) ? 1 : 17); end
    got = {resp_id, resp_dz, resp_result, resp_odd};
    total++; if (got !== exp) begin bad++; $display("FAIL %s_data: got %h want %h", name, got, exp); end
    step();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL %s_accept: resp_valid got %b want 0", name, resp_valid); end
  endtask

  task automatic test_single();
    logic [34:0] got;
    test_op("single", 0, 16'd1000, 8'd7, got);
    total++; if (got[31:0] !== {16'd142, 16'd6} || got[34:32] !== 3'b000) begin bad++; $display("FAIL single_const: got %h want id0 dz0 142 r6", got); end
  endtask

  task automatic test_div_zero();
    logic [34:0] got;
    test_op("divzero", 2, 16'h1234, 8'd0, got);
    total++; if (got[32:0] !== {1'b1, 16'hFFFF, 16'h1234}) begin bad++; $display("FAIL divzero_const: got %h want dz1 FFFF 1234", got); end
  endtask

  task automatic test_extremes();
    logic [34:0] got;
    test_op("max_div1", 1, 16'd65535, 8'd1, got);
    total++; if (got[31:0] !== {16'd65535, 16'd0}) begin bad++; $display("FAIL max_div1_const: got %h want FFFF r0", got[31:0]); end
    test_op("small_big", 3, 16'd5, 8'd200, got);
    total++; if (got[31:0] !== {16'd0, 16'd5}) begin bad++; $display("FAIL small_big_const: got %h want 0 r5", got[31:0]); end
  endtask

  // All requesters held valid: grants rotate and one op completes every 18 cycles.
  task automatic test_round_robin();
    logic [N-1:0] rdy;
    bit ok;
    int lat, pick, prev;
    int gcnt[N];
    logic [15:0] la[N];
    logic [7:0]  lb[N];
    logic [34:0] got, exp;
    test_reset();
    for (int j = 0; j < N; j++) begin
      gcnt[j] = 0;
      la[j] = 16'($urandom);
      lb[j] = 8'($urandom_range(1, 255));
      set_req(j, la[j], lb[j]);
    end
    req_valid = '1;
    resp_ready = 1'b1;
    prev = 0;
    for (int n = 0; n < 2 * N; n++) begin
      pick = rr_pick(req_valid);
      exp_q.push_back(model(pick, la[pick], lb[pick]));
      do_grant(rdy, ok);
      total++; if (!ok) begin bad++; $display("FAIL rr_grant: none within bound at op %0d", n); break; end
      total++; if (oh_idx(rdy) != pick) begin bad++; $display("FAIL rr_order: op %0d got %b want %0d", n, rdy, pick); end
      if (n > 0) begin
        total++; if (cyc - prev != 18) begin bad++; $display("FAIL rr_spacing: got %0d want 18", cyc - prev); end
      end
      prev = cyc;
      gcnt[pick]++;
      m_ptr = (pick + 1) % N;
      la[pick] = 16'($urandom);
      lb[pick] = 8'($urandom_range(1, 255));
      set_req(pick, la[pick], lb[pick]);
      wait_resp(lat, ok);
      total++; if (!ok) begin bad++; $display("FAIL rr_resp: none within bound at op %0d", n); break; end
      got = {resp_id, resp_dz, resp_result, resp_odd};
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL rr_data: op %0d got %h want %h", n, got, exp); end
    end
    for (int j = 0; j < N; j++) begin
      total++; if (gcnt[j] != 2) begin bad++; $display("FAIL rr_fair: req %0d got %0d grants want 2", j, gcnt[j]); end
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    logic [N-1:0] rdy;
    bit ok;
    int lat, stable_bad, rdy_bad;
    logic [15:0] a;
    logic [7:0] b;
    logic [34:0] exp;
    a = 16'($urandom);
    b = 8'($urandom_range(1, 255));
    set_req(3, a, b);
    resp_ready = 1'b0;
    req_valid = 4'b1000;
    exp = model(3, a, b);
    do_grant(rdy, ok);
    total++; if (!ok || oh_idx(rdy) != 3) begin bad++; $display("FAIL bp_grant: got %b want 1000", rdy); return; end
    m_ptr = 0;
    req_valid = '0;
    wait_resp(lat, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_resp: none within bound"); return; end
    req_valid = '1;
    stable_bad = 0;
    rdy_bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (resp_valid !== 1'b1 || {resp_id, resp_dz, resp_result, resp_odd} !== exp) stable_bad++;
      if (req_ready !== 4'b0) rdy_bad++;
    end
    total++; if (stable_bad != 0) begin bad++; $display("FAIL bp_stable: %0d unstable cycles want 0, last %h want %h", stable_bad, {resp_id, resp_dz, resp_result, resp_odd}, exp); end
    total++; if (rdy_bad != 0) begin bad++; $display("FAIL bp_req_ready: %0d cycles with grant want 0", rdy_bad); end
    resp_ready = 1'b1;
    req_valid = '0;
    step();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_accept: resp_valid got %b want 0", resp_valid); end
  endtask

  // Requests raised and dropped while busy leave no trace; idle cycles do not move the pointer.
  task automatic test_drop_and_ptr();
    logic [N-1:0] rdy;
    bit ok;
    int lat, pick, rbad;
    logic [34:0] exp;
    logic [34:0] got;
    test_op("drop_setup", 1, 16'($urandom), 8'($urandom_range(1, 255)), got);
    req_valid = 4'b0001;
    set_req(0, 16'd777, 8'd9);
    do_grant(rdy, ok);
    total++; if (!ok || oh_idx(rdy) != 0) begin bad++; $display("FAIL drop_grant0: got %b want 0001", rdy); return; end
    m_ptr = 1;
    req_valid = 4'b0110;
    rbad = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (req_ready !== 4'b0) rbad++;
    end
    req_valid = '0;
    wait_resp(lat, ok);
    total++; if (!ok || {resp_id, resp_dz, resp_result, resp_odd} !== model(0, 16'd777, 8'd9)) begin bad++; $display("FAIL drop_resp: got %h want %h", {resp_id, resp_dz, resp_result, resp_odd}, model(0, 16'd777, 8'd9)); end
    for (int c = 0; c < 6; c++) begin
      step();
      if (req_ready !== 4'b0) rbad++;
    end
    total++; if (rbad != 0) begin bad++; $display("FAIL drop_no_grant: %0d cycles with grant want 0", rbad); end
    for (int j = 0; j < N; j++) set_req(j, 16'($urandom), 8'($urandom_range(1, 255)));
    req_valid = 4'b1101;
    pick = rr_pick(req_valid);
    exp = model(pick, req_a[16*pick +: 16], req_b[8*pick +: 8]);
    do_grant(rdy, ok);
    total++; if (!ok || oh_idx(rdy) != pick) begin bad++; $display("FAIL drop_ptr_hold: got %b want %0d", rdy, pick); return; end
    m_ptr = (pick + 1) % N;
    req_valid = '0;
    wait_resp(lat, ok);
    total++; if (!ok || {resp_id, resp_dz, resp_result, resp_odd} !== exp) begin bad++; $display("FAIL drop_ptr_data: got %h want %h", {resp_id, resp_dz, resp_result, resp_odd}, exp); end
    step();
  endtask

  task automatic test_reset_mid_calc();
    logic [N-1:0] rdy;
    bit ok;
    int lat, seen;
    resp_ready = 1'b1;
    set_req(1, 16'($urandom), 8'($urandom_range(1, 255)));
    req_valid = 4'b0010;
    do_grant(rdy, ok);
    total++; if (!ok || oh_idx(rdy) != 1) begin bad++; $display("FAIL midrst_grant: got %b want 0010", rdy); return; end
    req_valid = '0;
    repeat (8) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_ptr = 0;
    total++; if ({resp_id, resp_dz, resp_result, resp_odd} !== 35'd0) begin bad++; $display("FAIL midrst_outputs: got %h want 0", {resp_id, resp_dz, resp_result, resp_odd}); end
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (resp_valid !== 1'b0) seen++;
      step();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midrst_no_resp: resp_valid high %0d cycles want 0", seen); end
    set_req(0, 16'd65535, 8'd255);
    set_req(3, 16'd100, 8'd3);
    req_valid = 4'b1001;
    do_grant(rdy, ok);
    total++; if (!ok || oh_idx(rdy) != 0) begin bad++; $display("FAIL midrst_ptr: got %b want 0001", rdy); return; end
    m_ptr = 1;
    req_valid = '0;
    wait_resp(lat, ok);
    total++; if (!ok || lat != 17 || resp_result !== 16'd257 || resp_odd !== 16'd0) begin bad++; $display("FAIL midrst_next_op: got q=%0d r=%0d lat=%0d want q=257 r=0 lat=17", resp_result, resp_odd, lat); end
    step();
  endtask

  task automatic test_random();
    logic [N-1:0] rdy, v;
    bit ok;
    int lat, pick, stall;
    logic [34:0] got, exp;
    for (int n = 0; n < 30; n++) begin
      for (int j = 0; j < N; j++) set_req(j, 16'($urandom), ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
      v = N'($urandom_range(1, (1 << N) - 1));
      req_valid = v;
      resp_ready = 1'b0;
      pick = rr_pick(v);
      exp = model(pick, req_a[16*pick +: 16], req_b[8*pick +: 8]);
      exp_q.push_back(exp);
      do_grant(rdy, ok);
      total++; if (!ok || oh_idx(rdy) != pick) begin bad++; $display("FAIL rand_grant: op %0d got %b want %0d", n, rdy, pick); end
      m_ptr = (pick + 1) % N;
      req_valid = '0;
      wait_resp(lat, ok);
      total++; if (!ok) begin bad++; $display("FAIL rand_resp: op %0d none within bound", n); break; end
      total++; if (lat != (exp[32] ? 1 : 17)) begin bad++; $display("FAIL rand_latency: op %0d got %0d want %0d", n, lat, exp[32] ? 1 : 17); end
      stall = $urandom_range(0, 3);
      repeat (stall) step();
      got = {resp_id, resp_dz, resp_result, resp_odd};
      exp = exp_q.pop_front();
      total++; if (resp_valid !== 1'b1 || got !== exp) begin bad++; $display("FAIL rand_data: op %0d got %h want %h", n, got, exp); end
      resp_ready = 1'b1;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_div_zero();
    test_extremes();
    test_round_robin();
    test_backpressure();
    test_drop_and_ptr();
    test_reset_mid_calc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

endmodule
